// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings and framing constants
package uart_pkg;

  // Frame states, shared by the transmitter and the receiver
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // s_ticks per bit period
  localparam int OVERSAMPLE = 16;

  // s_ticks spent in the stop period
  localparam int SB_1   = 16;
  localparam int SB_1P5 = 24;
  localparam int SB_2   = 32;

  // Tick counter must hold both a full bit period and the whole stop period
  function automatic int tick_width(input int sb_tick);
    int w;
    w = $clog2(sb_tick);
    return (w > 4) ? w : 4;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART serial transmitter driven by the shared 16x baud tick
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = SB_1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] tx_din,
  output logic            tx_done_tick,
  output logic            tx_busy,
  output logic            tx
);

  localparam int SW = tick_width(SB_TICK);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_LAST_BIT  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_LAST_STOP = SW'(SB_TICK - 1);
  localparam logic [SW-1:0] S_ONE       = SW'(1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);
  localparam logic [NW-1:0] N_ONE       = NW'(1);
  localparam logic          PAR_ODD_BIT = (PARITY_ODD != 0);
  localparam bit            HAS_PARITY  = (PARITY_EN != 0);

  uart_state_e     state_reg, state_next;
  logic [SW-1:0]   s_reg, s_next;
  logic [NW-1:0]   n_reg, n_next;
  logic [DBIT-1:0] b_reg, b_next;
  logic            p_reg, p_next;
  logic            tx_reg, tx_next;

  // State register with async reset; the line returns to idle-high at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      p_reg     <= 1'b0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      p_reg     <= p_next;
      tx_reg    <= tx_next;
    end
  end

  // Next-state logic: every timed state advances only on s_tick
  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    p_next     = p_reg;
    case (state_reg)
      ST_IDLE: begin
        // A tick arriving together with the start request is not counted
        if (tx_start) begin
          b_next     = tx_din;
          p_next     = (^tx_din) ^ PAR_ODD_BIT;
          s_next     = '0;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_reg == S_LAST_BIT) begin
            s_next     = '0;
            n_next     = '0;
            state_next = ST_DATA;
          end else begin
            s_next = s_reg + S_ONE;
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_reg == S_LAST_BIT) begin
            s_next = '0;
            b_next = b_reg >> 1;
            if (n_reg == N_LAST) begin
              state_next = HAS_PARITY ? ST_PARITY : ST_STOP;
            end else begin
              n_next = n_reg + N_ONE;
            end
          end else begin
            s_next = s_reg + S_ONE;
          end
        end
      end
      ST_PARITY: begin
        if (s_tick) begin
          if (s_reg == S_LAST_BIT) begin
            s_next     = '0;
            state_next = ST_STOP;
          end else begin
            s_next = s_reg + S_ONE;
          end
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (s_reg == S_LAST_STOP) begin
            s_next     = '0;
            state_next = ST_IDLE;
          end else begin
            s_next = s_reg + S_ONE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        s_next     = '0;
        n_next     = '0;
      end
    endcase
  end

  // Outputs: line level for the state being entered, plus status flags
  always_comb begin
    case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = b_next[0];
      ST_PARITY: tx_next = p_next;
      default:   tx_next = 1'b1;
    endcase
    tx_done_tick = (state_reg == ST_STOP) && s_tick && (s_reg == S_LAST_STOP);
    tx_busy      = (state_reg != ST_IDLE);
  end

  assign tx = tx_reg;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - randomized and directed self-checking bench for uart_tx
module tb_uart_tx;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       s_tick = 1'b0;
  logic       start_v [4];
  logic [8:0] din_v   [4];
  logic       tx_v    [4];
  logic       busy_v  [4];
  logic       done_v  [4];

  int dbit_c [4] = '{8, 8, 8, 5};
  int pen_c  [4] = '{0, 1, 1, 0};
  int podd_c [4] = '{0, 0, 1, 0};
  int sbt_c  [4] = '{SB_1, SB_1, SB_1, SB_2};

  int checks = 0;
  int errors = 0;

  int tick_div = 4;
  bit tick_en  = 1'b1;
  int tick_cnt = 0;

  uart_tx #(.DBIT(8)) dut0 (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_start(start_v[0]),
    .tx_din(din_v[0][7:0]), .tx_done_tick(done_v[0]), .tx_busy(busy_v[0]), .tx(tx_v[0])
  );
  uart_tx #(.DBIT(8), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_start(start_v[1]),
    .tx_din(din_v[1][7:0]), .tx_done_tick(done_v[1]), .tx_busy(busy_v[1]), .tx(tx_v[1])
  );
  uart_tx #(.DBIT(8), .PARITY_EN(1), .PARITY_ODD(1)) dut2 (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_start(start_v[2]),
    .tx_din(din_v[2][7:0]), .tx_done_tick(done_v[2]), .tx_busy(busy_v[2]), .tx(tx_v[2])
  );
  uart_tx #(.DBIT(5), .SB_TICK(SB_2)) dut3 (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_start(start_v[3]),
    .tx_din(din_v[3][4:0]), .tx_done_tick(done_v[3]), .tx_busy(busy_v[3]), .tx(tx_v[3])
  );

  always #5 clk = ~clk;

  // Baud tick: one clk wide, every tick_div clocks, paused when tick_en is low
  always @(posedge clk) begin
    #1;
    if (tick_en) begin
      s_tick = (tick_cnt == 0);
      tick_cnt = (tick_cnt + 1 >= tick_div) ? 0 : tick_cnt + 1;
    end else begin
      s_tick = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] word_mask(input int d);
    return 9'((1 << dbit_c[d]) - 1);
  endfunction

  function automatic int frame_ticks(input int d);
    return (1 + dbit_c[d] + pen_c[d]) * OVERSAMPLE + sbt_c[d];
  endfunction

  // Reference line level during the k-th counted tick of a frame (0-based)
  function automatic logic exp_lvl(input int d, input logic [8:0] wm, input int k);
    int b;
    b = k / OVERSAMPLE;
    if (b == 0) return 1'b0;
    if (b <= dbit_c[d]) return wm[b-1];
    if (pen_c[d] != 0 && b == dbit_c[d] + 1) return (^wm) ^ (podd_c[d] != 0);
    return 1'b1;
  endfunction

  // Waits for a cycle carrying s_tick, raises tx_start there, returns at its negedge
  task automatic align_and_start(input int d, input logic [8:0] w);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #2;
      if (s_tick) begin
        found = 1'b1;
        break;
      end
    end
    check($sformatf("tick_align_d%0d", d), 32'(found), 32'd1);
    start_v[d] = 1'b1;
    din_v[d]   = w;
    @(negedge clk);
  endtask

  // Called at the negedge of the accept cycle; observes the whole frame.
  // mode 0: drop start after accept; 1: hold start with w_next; 2: raise start with w_next in the done cycle
  task automatic run_frame(input int d, input logic [8:0] w, input int mode, input logic [8:0] w_next,
                           input int glitch_at, input logic [8:0] glitch_w, input int pause_at,
                           output int busy_cyc, output logic mid_bit);
    logic       smp[$];
    int         total, dones, done_idx, pause_left, bad, pidx;
    logic       held;
    bit         held_ok, stable, quiet;
    logic [8:0] wm, dec;
    total      = frame_ticks(d);
    dones      = 0;
    done_idx   = -1;
    pause_left = 0;
    bad        = 0;
    held       = 1'b0;
    held_ok    = 1'b0;
    stable     = 1'b1;
    quiet      = 1'b1;
    busy_cyc   = 0;
    wm         = w & word_mask(d);

    check($sformatf("accept_idle_d%0d", d), 32'(busy_v[d]), 32'd0);
    @(posedge clk); #2;
    start_v[d] = (mode == 1);
    din_v[d]   = (mode == 1) ? w_next : 9'($urandom);

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (busy_v[d] !== 1'b1) break;
      busy_cyc++;
      if (pause_left > 0 && !s_tick) begin
        if (!held_ok) begin
          held    = tx_v[d];
          held_ok = 1'b1;
        end else if (tx_v[d] !== held) begin
          stable = 1'b0;
        end
      end
      if (s_tick) smp.push_back(tx_v[d]);
      if (done_v[d] === 1'b1) begin
        dones++;
        done_idx = smp.size() - 1;
        if (mode == 2) begin
          start_v[d] = 1'b1;
          din_v[d]   = w_next;
        end
      end
      @(posedge clk); #2;
      if (c == glitch_at) begin
        start_v[d] = 1'b1;
        din_v[d]   = glitch_w;
      end else if (glitch_at >= 0 && c == glitch_at + 1) begin
        start_v[d] = 1'b0;
        din_v[d]   = 9'($urandom);
      end
      if (c == pause_at) begin
        tick_en    = 1'b0;
        pause_left = 60;
      end else if (pause_left > 0) begin
        pause_left--;
        if (pause_left == 0) tick_en = 1'b1;
      end
    end
    tick_en = 1'b1;

    check($sformatf("frame_end_d%0d", d), 32'(busy_v[d]), 32'd0);
    check($sformatf("tick_count_d%0d", d), 32'(smp.size()), 32'(total));
    foreach (smp[k]) if (smp[k] !== exp_lvl(d, wm, k)) bad++;
    check($sformatf("bit_levels_d%0d_w%0h", d, wm), 32'(bad), 32'd0);
    check($sformatf("done_pulses_d%0d", d), 32'(dones), 32'd1);
    check($sformatf("done_position_d%0d", d), 32'(done_idx), 32'(total - 1));
    check($sformatf("idle_line_d%0d", d), 32'(tx_v[d]), 32'd1);

    dec = '0;
    for (int i = 0; i < dbit_c[d]; i++)
      dec[i] = (smp.size() > OVERSAMPLE * (i + 1) + 8) ? smp[OVERSAMPLE * (i + 1) + 8] : 1'bx;
    check($sformatf("decoded_word_d%0d", d), 32'(dec), 32'(wm));

    pidx    = (1 + dbit_c[d]) * OVERSAMPLE + 8;
    mid_bit = (smp.size() > pidx) ? smp[pidx] : 1'bx;

    if (pause_at >= 0) check($sformatf("pause_hold_d%0d", d), 32'(stable && held_ok), 32'd1);

    if (mode == 0) begin
      repeat (20) begin
        @(negedge clk);
        if (busy_v[d] !== 1'b0) quiet = 1'b0;
      end
      check($sformatf("no_extra_frame_d%0d", d), 32'(quiet), 32'd1);
    end
  endtask

  initial begin
    int         bc;
    logic       mb;
    logic [8:0] w;
    for (int d = 0; d < 4; d++) begin
      start_v[d] = 1'b0;
      din_v[d]   = '0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("rst_tx_d%0d", d), 32'(tx_v[d]), 32'd1);
      check($sformatf("rst_busy_d%0d", d), 32'(busy_v[d]), 32'd0);
      check($sformatf("rst_done_d%0d", d), 32'(done_v[d]), 32'd0);
    end
    @(posedge clk); #2;
    reset_n = 1'b1;
    repeat (4) @(posedge clk);

    // 8N1 0xA5, one bit = 16 ticks of 4 clk, busy for the whole 640-clk frame
    tick_div = 4;
    align_and_start(0, 9'h0A5);
    run_frame(0, 9'h0A5, 0, 9'h0, -1, 9'h0, -1, bc, mb);
    check("t1_busy_clks", 32'(bc), 32'd640);
    check("t1_stop_level", 32'(mb), 32'd1);

    // Parity even and odd on 0xA5
    align_and_start(1, 9'h0A5);
    run_frame(1, 9'h0A5, 0, 9'h0, -1, 9'h0, -1, bc, mb);
    check("t2_parity_even", 32'(mb), 32'd0);
    align_and_start(2, 9'h0A5);
    run_frame(2, 9'h0A5, 0, 9'h0, -1, 9'h0, -1, bc, mb);
    check("t2_parity_odd", 32'(mb), 32'd1);

    // Back-to-back 0x3C then 0xFF with tx_start held high
    align_and_start(0, 9'h03C);
    run_frame(0, 9'h03C, 1, 9'h0FF, -1, 9'h0, -1, bc, mb);
    run_frame(0, 9'h0FF, 0, 9'h0, -1, 9'h0, -1, bc, mb);

    // Start pulse with 0x55 during DATA of a 0x0F frame is ignored
    align_and_start(0, 9'h00F);
    run_frame(0, 9'h00F, 0, 9'h0, 150, 9'h055, -1, bc, mb);

    // Ticks paused mid-frame: line holds, frame resumes intact
    align_and_start(0, 9'h06B);
    run_frame(0, 9'h06B, 0, 9'h0, -1, 9'h0, 100, bc, mb);

    // Async reset while bit 3 of an all-zero word is on the line
    align_and_start(0, 9'h000);
    @(posedge clk); #2;
    start_v[0] = 1'b0;
    repeat (287) @(posedge clk);
    #2;
    check("t5_pre_tx", 32'(tx_v[0]), 32'd0);
    check("t5_pre_busy", 32'(busy_v[0]), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t5_rst_tx", 32'(tx_v[0]), 32'd1);
    check("t5_rst_busy", 32'(busy_v[0]), 32'd0);
    check("t5_rst_done", 32'(done_v[0]), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    align_and_start(0, 9'h081);
    run_frame(0, 9'h081, 0, 9'h0, -1, 9'h0, -1, bc, mb);

    // Two stop bits, 5 data bits; start raised in the done cycle waits one clk
    align_and_start(3, 9'h016);
    run_frame(3, 9'h016, 2, 9'h009, -1, 9'h0, -1, bc, mb);
    run_frame(3, 9'h009, 0, 9'h0, -1, 9'h0, -1, bc, mb);

    // Random words at random tick rates on every configuration
    for (int r = 0; r < 3; r++) begin
      for (int d = 0; d < 4; d++) begin
        tick_div = $urandom_range(2, 5);
        w = 9'($urandom);
        align_and_start(d, w);
        run_frame(d, w, 0, 9'h0, -1, 9'h0, -1, bc, mb);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
